pitch_period_ctrl: RTL and testbench

//  Controller sequencing the mic zero-crossing period datapath: hysteresis edge detect on
//  16-bit signed mic samples, collects N_AVG consecutive periods, checks stability, emits the

---
 rtl/pitch_period_ctrl.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_pitch_period_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pitch_period_ctrl.sv
// -----------------------------------------------------------------------------
// pitch_period_ctrl
//
// Measures the fundamental period of a mic sample stream by zero-crossing
// timing with hysteresis. A rising edge is accepted after DEBOUNCE consecutive
// samples below -THR followed by DEBOUNCE consecutive samples above +THR. The
// first accepted edge only arms the measurement. Each later edge closes one
// period. After N_AVG periods the set is checked for stability. A stable set
// is offered as an averaged period over a valid/ready handshake.
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   enable        run measurement; low forces IDLE and drops any pending result
//   sample        signed 16-bit mic sample
//   sample_we     sample strobe, at most one per clk
//   period_out    averaged period in samples, stable while period_valid
//   period_valid  result available
//   period_ready  consumer accepts result (transfer = valid & ready)
//   locked        last stability check passed
//   timeout       one-cycle pulse when no edge is accepted within TIMEOUT samples
// -----------------------------------------------------------------------------
module pitch_period_ctrl #(
   parameter int W_CNT     = 16,
   parameter int THR       = 120,
   parameter int DEBOUNCE  = 16,
   parameter int N_AVG     = 4,
   parameter int TOL_SHIFT = 3,
   parameter int TIMEOUT   = 4095
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               enable,
   input  logic signed [15:0] sample,
   input  logic               sample_we,
   output logic [W_CNT-1:0]   period_out,
   output logic               period_valid,
   input  logic               period_ready,
   output logic               locked,
   output logic               timeout
);

   localparam int LOG_N = $clog2(N_AVG);
   localparam int SUM_W = W_CNT + LOG_N;
   localparam int DB_W  = $clog2(DEBOUNCE + 1);
   localparam int NP_W  = $clog2(N_AVG + 1);

   localparam logic signed [15:0] THR_POS = 16'(THR);
   localparam logic signed [15:0] THR_NEG = -THR_POS;
   localparam logic [DB_W-1:0]    DB_C    = DB_W'(DEBOUNCE);
   localparam logic [NP_W-1:0]    NP_C    = NP_W'(N_AVG);
   localparam logic [W_CNT-1:0]   TMO_C   = W_CNT'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_LOW,
      WAIT_HIGH,
      CHECK,
      OUTPUT
   } state_t;

   state_t            state_reg, state_next;
   logic [W_CNT-1:0]  samp_cnt_reg, samp_cnt_next;
   logic [DB_W-1:0]   cnt_lo_reg, cnt_lo_next;
   logic [DB_W-1:0]   cnt_hi_reg, cnt_hi_next;
   logic [NP_W-1:0]   n_per_reg, n_per_next;
   logic              armed_reg, armed_next;
   logic [SUM_W-1:0]  sum_reg, sum_next;
   logic [W_CNT-1:0]  min_reg, min_next;
   logic [W_CNT-1:0]  max_reg, max_next;
   logic [W_CNT-1:0]  period_out_reg, period_out_next;
   logic              valid_reg, valid_next;
   logic              locked_reg, locked_next;
   logic              timeout_reg, timeout_next;

   // Helper terms shared by the next-state logic.
   logic [W_CNT-1:0]  samp_inc;
   logic [DB_W-1:0]   cnt_lo_inc;
   logic [DB_W-1:0]   cnt_hi_inc;
   logic [NP_W-1:0]   n_per_inc;
   logic              is_low;
   logic              is_high;
   logic              lo_done;
   logic              hi_edge;
   logic [SUM_W-1:0]  avg_full;
   logic [SUM_W-1:0]  tol_full;
   logic [SUM_W-1:0]  spread_full;
   logic              stable;

   // The sample counter saturates instead of wrapping, so a period count can
   // never alias back to a small value.
   assign samp_inc   = (&samp_cnt_reg) ? samp_cnt_reg : samp_cnt_reg + 1'b1;
   assign cnt_lo_inc = cnt_lo_reg + 1'b1;
   assign cnt_hi_inc = cnt_hi_reg + 1'b1;
   assign n_per_inc  = n_per_reg + 1'b1;

   // Strict comparisons: a sample sitting exactly on a threshold does not qualify.
   assign is_low  = (sample < THR_NEG);
   assign is_high = (sample > THR_POS);

   assign lo_done = (state_reg == WAIT_LOW)  && sample_we && is_low  && (cnt_lo_inc == DB_C);
   assign hi_edge = (state_reg == WAIT_HIGH) && sample_we && is_high && (cnt_hi_inc == DB_C);

   // Stability check, carried at full sum width so that no bit is discarded
   // before the comparison. The average is truncated.
   assign avg_full    = sum_reg >> LOG_N;
   assign tol_full    = avg_full >> TOL_SHIFT;
   assign spread_full = SUM_W'(max_reg) - SUM_W'(min_reg);
   assign stable      = (spread_full <= tol_full);

   always_comb begin
      state_next      = state_reg;
      samp_cnt_next   = samp_cnt_reg;
      cnt_lo_next     = cnt_lo_reg;
      cnt_hi_next     = cnt_hi_reg;
      n_per_next      = n_per_reg;
      armed_next      = armed_reg;
      sum_next        = sum_reg;
      min_next        = min_reg;
      max_next        = max_reg;
      period_out_next = period_out_reg;
      valid_next      = valid_reg;
      locked_next     = locked_reg;
      timeout_next    = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (enable) begin
               state_next    = WAIT_LOW;
               samp_cnt_next = '0;
               n_per_next    = '0;
               armed_next    = 1'b0;
               cnt_lo_next   = '0;
               cnt_hi_next   = '0;
            end
         end

         WAIT_LOW, WAIT_HIGH: begin
            if (sample_we) begin
               samp_cnt_next = samp_inc;

               if (state_reg == WAIT_LOW) begin
                  if (lo_done) begin
                     cnt_lo_next = '0;
                     state_next  = WAIT_HIGH;
                  end else if (is_low) begin
                     cnt_lo_next = cnt_lo_inc;
                  end else begin
                     cnt_lo_next = '0;
                  end
               end else begin
                  if (hi_edge) begin
                     cnt_hi_next = '0;
                  end else if (is_high) begin
                     cnt_hi_next = cnt_hi_inc;
                  end else begin
                     cnt_hi_next = '0;
                  end
               end

               // An accepted edge on the very sample that would reach the
               // timeout still counts as an edge: the period closed in time.
               if (hi_edge) begin
                  samp_cnt_next = '0;
                  state_next    = WAIT_LOW;
                  if (!armed_reg) begin
                     armed_next = 1'b1;
                  end else begin
                     sum_next   = sum_reg + SUM_W'(samp_inc);
                     n_per_next = n_per_inc;
                     if (n_per_reg == '0) begin
                        min_next = samp_inc;
                        max_next = samp_inc;
                     end else begin
                        if (samp_inc < min_reg) min_next = samp_inc;
                        if (samp_inc > max_reg) max_next = samp_inc;
                     end
                     if (n_per_inc == NP_C) state_next = CHECK;
                  end
               end else if (samp_inc >= TMO_C) begin
                  timeout_next  = 1'b1;
                  locked_next   = 1'b0;
                  sum_next      = '0;
                  min_next      = '0;
                  max_next      = '0;
                  n_per_next    = '0;
                  armed_next    = 1'b0;
                  samp_cnt_next = '0;
                  cnt_lo_next   = '0;
                  cnt_hi_next   = '0;
                  state_next    = WAIT_LOW;
               end
            end
         end

         CHECK: begin
            if (stable) begin
               period_out_next = avg_full[W_CNT-1:0];
               valid_next      = 1'b1;
               locked_next     = 1'b1;
               state_next      = OUTPUT;
            end else begin
               // Keep armed: the edge that closed the last period starts the
               // next set, so measurement resumes without losing a period.
               locked_next = 1'b0;
               sum_next    = '0;
               min_next    = '0;
               max_next    = '0;
               n_per_next  = '0;
               state_next  = WAIT_LOW;
            end
         end

         OUTPUT: begin
            if (valid_reg && period_ready) begin
               valid_next    = 1'b0;
               sum_next      = '0;
               min_next      = '0;
               max_next      = '0;
               n_per_next    = '0;
               samp_cnt_next = '0;
               armed_next    = 1'b0;
               cnt_lo_next   = '0;
               cnt_hi_next   = '0;
               state_next    = WAIT_LOW;
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // Disable overrides everything, including a result still on offer.
      if (!enable) begin
         state_next    = IDLE;
         valid_next    = 1'b0;
         locked_next   = 1'b0;
         timeout_next  = 1'b0;
         samp_cnt_next = '0;
         cnt_lo_next   = '0;
         cnt_hi_next   = '0;
         n_per_next    = '0;
         armed_next    = 1'b0;
         sum_next      = '0;
         min_next      = '0;
         max_next      = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= IDLE;
         samp_cnt_reg   <= '0;
         cnt_lo_reg     <= '0;
         cnt_hi_reg     <= '0;
         n_per_reg      <= '0;
         armed_reg      <= 1'b0;
         sum_reg        <= '0;
         min_reg        <= '0;
         max_reg        <= '0;
         period_out_reg <= '0;
         valid_reg      <= 1'b0;
         locked_reg     <= 1'b0;
         timeout_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         samp_cnt_reg   <= samp_cnt_next;
         cnt_lo_reg     <= cnt_lo_next;
         cnt_hi_reg     <= cnt_hi_next;
         n_per_reg      <= n_per_next;
         armed_reg      <= armed_next;
         sum_reg        <= sum_next;
         min_reg        <= min_next;
         max_reg        <= max_next;
         period_out_reg <= period_out_next;
         valid_reg      <= valid_next;
         locked_reg     <= locked_next;
         timeout_reg    <= timeout_next;
      end
   end

   assign period_out   = period_out_reg;
   assign period_valid = valid_reg;
   assign locked       = locked_reg;
   assign timeout      = timeout_reg;

endmodule

// File: tb/tb_pitch_period_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pitch_period_ctrl
//
// Directed bench for pitch_period_ctrl. Waveforms are square segments: each
// cycle is a run of low samples followed by a run of 50 high samples. An edge
// is accepted on the 16th high sample, so the period measured at a cycle is
// (previous high run) + (this low run) = 50 + low run, i.e. the cycle length.
// Samples are strobed every other clock. A table of measurement sets is run
// first, then hand-written sequences cover latency, back-pressure, disable,
// timeout and reset.
// -----------------------------------------------------------------------------
module tb_pitch_period_ctrl;

   localparam int W_CNT = 16;

   logic                     clk          = 1'b0;
   logic                     reset_n      = 1'b0;
   logic                     enable       = 1'b0;
   logic signed [15:0]       sample       = '0;
   logic                     sample_we    = 1'b0;
   logic                     period_ready = 1'b1;
   logic [W_CNT-1:0]         period_out;
   logic                     period_valid;
   logic                     locked;
   logic                     timeout;

   int checks = 0;
   int errors = 0;

   // Handshake / pulse monitor, sampled at the active edge.
   int               xfer_cnt     = 0;
   int               valid_cycles = 0;
   int               tmo_cnt      = 0;
   logic [W_CNT-1:0] last_xfer    = '0;

   always #5 clk = ~clk;

   pitch_period_ctrl #(
      .W_CNT     (16),
      .THR       (120),
      .DEBOUNCE  (16),
      .N_AVG     (4),
      .TOL_SHIFT (3),
      .TIMEOUT   (4095)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .sample       (sample),
      .sample_we    (sample_we),
      .period_out   (period_out),
      .period_valid (period_valid),
      .period_ready (period_ready),
      .locked       (locked),
      .timeout      (timeout)
   );

   always @(posedge clk) begin
      if (period_valid === 1'b1) valid_cycles <= valid_cycles + 1;
      if (period_valid === 1'b1 && period_ready === 1'b1) begin
         xfer_cnt  <= xfer_cnt + 1;
         last_xfer <= period_out;
      end
      if (timeout === 1'b1) tmo_cnt <= tmo_cnt + 1;
   end

   typedef struct {
      string name;
      int    amp;
      int    p0, p1, p2, p3;
      int    exp_xfer;
      int    exp_period;
      int    exp_locked;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end else begin
         $display("ok   %s: %0d", name, act);
      end
   endtask

   // One sample strobe, then one idle clock.
   task automatic put(input int s);
      @(negedge clk);
      sample    = 16'(s);
      sample_we = 1'b1;
      @(negedge clk);
      sample_we = 1'b0;
   endtask

   task automatic cycle(input int amp, input int lo, input int hi);
      for (int i = 0; i < lo; i++) put(-amp);
      for (int i = 0; i < hi; i++) put(amp);
   endtask

   // Arming cycle followed by four measured periods.
   task automatic run_set(input int amp, input int p0, input int p1, input int p2, input int p3);
      cycle(amp, 50, 50);
      cycle(amp, p0 - 50, 50);
      cycle(amp, p1 - 50, 50);
      cycle(amp, p2 - 50, 50);
      cycle(amp, p3 - 50, 50);
   endtask

   task automatic restart();
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      enable = 1'b1;
   endtask

   int x0, v0, t0;
   int held_ok;

   initial begin
      vecs[0] = '{"square_100",    2000, 100, 100, 100, 100, 1, 100, 1};
      vecs[1] = '{"jitter_96_104", 1000,  96, 100, 104, 100, 1, 100, 1};
      vecs[2] = '{"unstable_80_120", 2000, 80, 120, 80, 120, 0,   0, 0};
      vecs[3] = '{"avg_truncate",  2000,  98,  99, 100, 101, 1,  99, 1};
      vecs[4] = '{"tol_equal",     2000,  94, 106, 100, 100, 1, 100, 1};
      vecs[5] = '{"tol_over",      2000,  94, 107, 100, 100, 0,   0, 0};
      vecs[6] = '{"amp_at_thr",     120, 100, 100, 100, 100, 0,   0, 0};
      vecs[7] = '{"amp_thr_plus1",  121, 100, 100, 100, 100, 1, 100, 1};
      vecs[8] = '{"long_200",      2000, 200, 190, 210, 200, 1, 200, 1};

      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      chk("reset_period_out", 32'(period_out), 0);
      chk("reset_valid", 32'(period_valid), 0);
      chk("reset_locked", 32'(locked), 0);
      chk("reset_timeout", 32'(timeout), 0);
      reset_n = 1'b1;

      // ---------------- table-driven measurement sets ----------------
      period_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         x0 = xfer_cnt;
         v0 = valid_cycles;
         restart();
         run_set(vecs[i].amp, vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3);
         chk({vecs[i].name, "_xfers"}, 32'(xfer_cnt - x0), 32'(vecs[i].exp_xfer));
         chk({vecs[i].name, "_valid_clks"}, 32'(valid_cycles - v0), 32'(vecs[i].exp_xfer));
         chk({vecs[i].name, "_locked"}, 32'(locked), 32'(vecs[i].exp_locked));
         if (vecs[i].exp_xfer > 0)
            chk({vecs[i].name, "_period"}, 32'(last_xfer), 32'(vecs[i].exp_period));
      end

      // ---------------- fail after pass clears locked, then recovers ----------------
      restart();
      run_set(2000, 100, 100, 100, 100);
      chk("pre_fail_locked", 32'(locked), 1);
      x0 = xfer_cnt;
      run_set(2000, 80, 120, 80, 120);
      chk("fail_locked_cleared", 32'(locked), 0);
      chk("fail_no_xfer", 32'(xfer_cnt - x0), 0);
      // Still armed: four more stable cycles give a result without re-arming.
      for (int k = 0; k < 4; k++) cycle(2000, 50, 50);
      chk("recover_xfer", 32'(xfer_cnt - x0), 1);
      chk("recover_period", 32'(last_xfer), 100);
      chk("recover_locked", 32'(locked), 1);

      // ---------------- latency and back-pressure ----------------
      period_ready = 1'b0;
      restart();
      x0 = xfer_cnt;
      for (int k = 0; k < 4; k++) cycle(2000, 50, 50);
      for (int k = 0; k < 50; k++) put(-2000);
      for (int k = 0; k < 15; k++) put(2000);
      @(negedge clk);
      sample    = 16'sd2000;
      sample_we = 1'b1;
      @(negedge clk);
      sample_we = 1'b0;
      chk("latency_1clk_valid", 32'(period_valid), 0);
      @(negedge clk);
      chk("latency_2clk_valid", 32'(period_valid), 1);
      chk("latency_2clk_period", 32'(period_out), 100);
      held_ok = 1;
      for (int k = 0; k < 250; k++) begin
         put(((k % 20) < 10) ? -3000 : 3000);
         if (period_valid !== 1'b1 || period_out !== 16'd100) held_ok = 0;
      end
      chk("hold_stable_500clk", 32'(held_ok), 1);
      chk("hold_no_xfer", 32'(xfer_cnt - x0), 0);
      @(negedge clk);
      period_ready = 1'b1;
      @(negedge clk);
      chk("hold_release_valid", 32'(period_valid), 0);
      chk("hold_release_xfer", 32'(xfer_cnt - x0), 1);
      chk("hold_release_period", 32'(last_xfer), 100);

      // ---------------- disable while valid, then re-enable ----------------
      period_ready = 1'b0;
      restart();
      run_set(2000, 100, 100, 100, 100);
      chk("dis_pre_valid", 32'(period_valid), 1);
      x0 = xfer_cnt;
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      chk("dis_valid", 32'(period_valid), 0);
      chk("dis_locked", 32'(locked), 0);
      chk("dis_no_xfer", 32'(xfer_cnt - x0), 0);
      period_ready = 1'b1;
      enable       = 1'b1;
      for (int k = 0; k < 4; k++) cycle(2000, 50, 50);
      chk("reen_first_edge_arms", 32'(xfer_cnt - x0), 0);
      cycle(2000, 50, 50);
      chk("reen_xfer", 32'(xfer_cnt - x0), 1);
      chk("reen_period", 32'(last_xfer), 100);

      // ---------------- timeout ----------------
      t0 = tmo_cnt;
      for (int k = 0; k < 4000; k++) put(0);
      chk("tmo_not_yet", 32'(tmo_cnt - t0), 0);
      chk("tmo_locked_kept", 32'(locked), 1);
      for (int k = 0; k < 200; k++) put(0);
      chk("tmo_pulse_once", 32'(tmo_cnt - t0), 1);
      chk("tmo_locked_cleared", 32'(locked), 0);

      restart();
      t0 = tmo_cnt;
      for (int k = 0; k < 4094; k++) put(0);
      chk("tmo_4094_none", 32'(tmo_cnt - t0), 0);
      put(0);
      chk("tmo_4095_high", 32'(timeout), 1);
      @(negedge clk);
      chk("tmo_pulse_width", 32'(timeout), 0);
      chk("tmo_4095_count", 32'(tmo_cnt - t0), 1);
      x0 = xfer_cnt;
      run_set(2000, 100, 100, 100, 100);
      chk("tmo_recover_xfer", 32'(xfer_cnt - x0), 1);
      chk("tmo_recover_period", 32'(last_xfer), 100);

      // ---------------- asynchronous reset mid-operation ----------------
      period_ready = 1'b0;
      restart();
      run_set(2000, 104, 104, 104, 104);
      chk("rst_pre_valid", 32'(period_valid), 1);
      chk("rst_pre_period", 32'(period_out), 104);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_valid", 32'(period_valid), 0);
      chk("rst_async_period", 32'(period_out), 0);
      chk("rst_async_locked", 32'(locked), 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
